pipe_ctrl: RTL and testbench

Pipeline hold/flush controller for the RV32 core. It merges stall and redirect requests from ex, the memory bus and the debug port, and drives the single hold code and the jump redirect seen by pc_reg, if_id and id_ex. It also runs the debug halt/drain/resume sequence and keeps a stall-cycle counter. It sits between ex and the front-end stages, replacing the direct ex→pc_reg/if_id/id_ex hold and jump wiring.

---
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold/flush controller with debug halt/drain/resume
// and a saturating stall-cycle counter.
//
// Ports:
//   clk, rst          core clock, async active-high reset
//   ex_jump_flag_i    ex redirect request
//   ex_jump_addr_i    ex redirect target
//   ex_hold_req_i     ex multi-cycle op busy
//   mem_busy_i        ram port busy, fetch waits
//   halt_req_i        debug halt request (level)
//   resume_req_i      debug resume request (level)
//   cnt_clr_i         sync clear of the stall counter
//   hold_flag_o       000 NONE, 001 PC, 010 IF, 011 ID
//   jump_flag_o       redirect to pc_reg
//   jump_addr_o       redirect target (0 when no redirect)
//   halted_o          core halted, pipeline empty
//   halt_ack_o        one-cycle pulse on halt entry
//   stall_cnt_o       held-cycle count, saturating
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_jump_flag_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic             ex_hold_req_i,
    input  logic             mem_busy_i,
    input  logic             halt_req_i,
    input  logic             resume_req_i,
    input  logic             cnt_clr_i,
    output logic [2:0]       hold_flag_o,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic             halted_o,
    output logic             halt_ack_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ID   = 3'b011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_RESUME
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DW-1:0]    drain_q;
    logic [DW-1:0]    drain_d;
    logic             halted_q;
    logic             ack_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        hold_flag_o = HOLD_NONE;
        jump_flag_o = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (ex_jump_flag_i) begin
                    jump_flag_o = 1'b1;
                    hold_flag_o = HOLD_ID;
                end else if (ex_hold_req_i) begin
                    hold_flag_o = HOLD_ID;
                end else if (mem_busy_i) begin
                    hold_flag_o = HOLD_IF;
                end
                // a pending jump or ex op must finish before draining
                if (halt_req_i && !ex_jump_flag_i && !ex_hold_req_i) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (ex_jump_flag_i) begin
                    // redirect refills the front end: restart the drain
                    jump_flag_o = 1'b1;
                    hold_flag_o = HOLD_ID;
                    drain_d     = DRAIN_LOAD;
                end else if (ex_hold_req_i) begin
                    hold_flag_o = HOLD_ID;
                end else begin
                    hold_flag_o = HOLD_IF;
                    if (drain_q <= DRAIN_ONE) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DRAIN_ONE;
                    end
                end
            end
            ST_HALTED: begin
                hold_flag_o = HOLD_ID;
                if (resume_req_i && !halt_req_i) begin
                    state_d = ST_RESUME;
                end
            end
            ST_RESUME: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    assign jump_addr_o = jump_flag_o ? ex_jump_addr_i : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == ST_HALTED);
            ack_q    <= (state_d == ST_HALTED) && (state_q != ST_HALTED);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (hold_flag_o != HOLD_NONE && state_q != ST_HALTED
                     && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign halted_o    = halted_q;
    assign halt_ack_o  = ack_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + random checks of pipe_ctrl against a
// behavioural model of the hold/halt/counter rules.
module tb_pipe_ctrl;

    localparam int DC    = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             jf = 1'b0;
    logic [31:0]      ja = '0;
    logic             eh = 1'b0;
    logic             mb = 1'b0;
    logic             hr = 1'b0;
    logic             rr = 1'b0;
    logic             cc = 1'b0;
    logic [2:0]       hold;
    logic             jfo;
    logic [31:0]      jao;
    logic             halted;
    logic             ack;
    logic [CNT_W-1:0] cnt;

    int n_vec = 0;
    int n_bad = 0;

    // model: mode 0 running, 1 draining, 2 halted, 3 resuming
    int m_mode  = 0;
    int m_left  = 0;
    int m_cnt   = 0;
    bit m_ack   = 0;

    pipe_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_jump_flag_i(jf),
        .ex_jump_addr_i(ja),
        .ex_hold_req_i (eh),
        .mem_busy_i    (mb),
        .halt_req_i    (hr),
        .resume_req_i  (rr),
        .cnt_clr_i     (cc),
        .hold_flag_o   (hold),
        .jump_flag_o   (jfo),
        .jump_addr_o   (jao),
        .halted_o      (halted),
        .halt_ack_o    (ack),
        .stall_cnt_o   (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_left = 0;
        m_cnt  = 0;
        m_ack  = 0;
    endtask

    // drive one cycle, check outputs mid-cycle, advance model on the edge
    task automatic step(input bit j, input logic [31:0] a, input bit h,
                        input bit m, input bit hq, input bit r,
                        input bit c);
        int  e_hold;
        bit  e_jump;
        jf = j; ja = a; eh = h; mb = m; hr = hq; rr = r; cc = c;
        e_hold = 0;
        e_jump = 0;
        case (m_mode)
            2: e_hold = 3;
            3: e_hold = 0;
            1: begin
                e_jump = j;
                e_hold = (j || h) ? 3 : 2;
            end
            default: begin
                e_jump = j;
                e_hold = (j || h) ? 3 : (m ? 2 : 0);
            end
        endcase
        #4;
        chk("hold", 64'(hold), 64'(e_hold));
        chk("jump", 64'(jfo), 64'(e_jump));
        chk("jaddr", 64'(jao), e_jump ? 64'(a) : 64'h0);
        chk("halted", 64'(halted), 64'(m_mode == 2));
        chk("ack", 64'(ack), 64'(m_ack));
        chk("cnt", 64'(cnt), 64'(m_cnt));
        @(posedge clk);
        if (c) m_cnt = 0;
        else if (e_hold != 0 && m_mode != 2 && m_cnt < CMAX) m_cnt++;
        m_ack = 0;
        case (m_mode)
            2: if (r && !hq) m_mode = 3;
            3: m_mode = 0;
            1: begin
                if (j) m_left = DC;
                else if (!h) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 2;
                        m_ack  = 1;
                    end
                end
            end
            default: if (hq && !j && !h) begin
                m_mode = 1;
                m_left = DC;
            end
        endcase
        #1;
    endtask

    task automatic async_reset();
        jf = 0; eh = 0; mb = 0; hr = 0; rr = 0; cc = 0;
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_cnt", 64'(cnt), 64'h0);
        chk("rst_hold", 64'(hold), 64'h0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("init_hold", 64'(hold), 64'h0);
        chk("init_halted", 64'(halted), 64'h0);
        chk("init_cnt", 64'(cnt), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // jump then quiet cycle
        step(1, 32'h40, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        chk("jump_cnt", 64'(cnt), 64'h1);

        // priority ladder
        step(1, 32'h1234, 1, 1, 0, 0, 0);
        step(0, 32'h1234, 1, 1, 0, 0, 0);
        step(0, 32'h0, 0, 1, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);

        // halt, hold in HALTED, resume
        step(0, 32'h0, 0, 0, 1, 0, 0);
        step(0, 32'h0, 0, 0, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        chk("halt_lat", 64'(halted), 64'h1);
        chk("halt_ack", 64'(ack), 64'h1);
        step(1, 32'h80, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 1, 1, 0);
        step(0, 32'h0, 0, 0, 0, 1, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);

        // jump on second drain cycle restarts the drain
        step(0, 32'h0, 0, 0, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h100, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        chk("drain_jump", 64'(halted), 64'h1);
        step(0, 32'h0, 0, 0, 0, 1, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);

        // counter saturation then clear under hold
        for (int i = 0; i < CMAX + 3; i++)
            step(0, 32'h0, 1, 0, 0, 0, 0);
        chk("cnt_sat", 64'(cnt), 64'(CMAX));
        step(0, 32'h0, 1, 0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0, 0, 0);

        // async reset mid-drain and while halted
        step(0, 32'h0, 0, 1, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        async_reset();
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        async_reset();
        step(0, 32'h0, 0, 0, 0, 0, 0);

        // random traffic
        begin
            bit hlev;
            hlev = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) hlev = ~hlev;
                step($urandom_range(0, 9) == 0, $urandom,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0, hlev,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 499) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
